// File: rtl/divide_seq.sv
// Iterative radix-2 restoring divider with fixed-point fractional quotient, sign-magnitude or
// two's-complement operands, start/busy/valid handshake, divide-by-zero and overflow saturation.
module divide_seq #(
  parameter int unsigned N_BITS_DIVIDEND = 32,
  parameter int unsigned N_BITS_DIVISOR  = 32,
  parameter int unsigned N_BITS_QUOTIENT = 32,
  parameter int unsigned FRAC_BITS       = 0,
  parameter int unsigned SIGN_MAG        = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [N_BITS_DIVIDEND-1:0] dividend,
  input  logic [N_BITS_DIVISOR-1:0]  divisor,
  output logic                       busy,
  output logic                       valid,
  output logic [N_BITS_QUOTIENT-1:0] final_quotient,
  output logic [N_BITS_DIVISOR-1:0]  remainder,
  output logic                       div_zero,
  output logic                       overflow
);

  localparam int unsigned NDD  = N_BITS_DIVIDEND;
  localparam int unsigned NDV  = N_BITS_DIVISOR;
  localparam int unsigned NQ   = N_BITS_QUOTIENT;
  localparam int unsigned MD   = (SIGN_MAG != 0) ? NDD - 1 : NDD;
  localparam int unsigned MV   = (SIGN_MAG != 0) ? NDV - 1 : NDV;
  localparam int unsigned ITER = MD + FRAC_BITS;
  localparam int unsigned QM   = NQ - 1;
  localparam int unsigned CW   = $clog2(ITER + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]      state;
  logic [ITER-1:0] dvd;
  logic [MV-1:0]   bmag;
  logic            sgn;
  logic [MV-1:0]   rem;
  logic [ITER-1:0] quot;
  logic [CW-1:0]   cnt;

  // Operand conversion at accept
  logic [MD-1:0] a_mag;
  logic [MV-1:0] b_mag;
  logic          a_sgn, b_sgn;

  always_comb begin
    if (SIGN_MAG != 0) begin
      a_mag = MD'(dividend);
      b_mag = MV'(divisor);
    end else begin
      a_mag = MD'(dividend[NDD-1] ? -dividend : dividend);
      b_mag = MV'(divisor[NDV-1] ? -divisor : divisor);
    end
    // A magnitude of zero is always positive (covers sign-magnitude negative zero).
    a_sgn = dividend[NDD-1] && (a_mag != '0);
    b_sgn = divisor[NDV-1] && (b_mag != '0);
  end

  // One restoring step
  logic [MV:0]   trial;
  logic [MV:0]   diff;
  logic          ge;

  always_comb begin
    trial = {rem, dvd[ITER-1]};
    diff  = trial - {1'b0, bmag};
    ge    = trial >= {1'b0, bmag};
  end

  // Result formatting with saturation to the output magnitude range
  logic          dz;
  logic          q_ovf;
  logic [QM-1:0] mag_sat;
  logic          res_neg;
  logic [NQ-1:0] q_fmt;

  always_comb begin
    dz      = (bmag == '0);
    q_ovf   = (quot >> QM) != '0;
    mag_sat = (dz || q_ovf) ? '1 : QM'(quot);
    res_neg = sgn && (mag_sat != '0);
    if (SIGN_MAG != 0) begin
      q_fmt = {res_neg, mag_sat};
    end else begin
      q_fmt = res_neg ? -{1'b0, mag_sat} : {1'b0, mag_sat};
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      dvd            <= '0;
      bmag           <= '0;
      sgn            <= 1'b0;
      rem            <= '0;
      quot           <= '0;
      cnt            <= '0;
      valid          <= 1'b0;
      final_quotient <= '0;
      remainder      <= '0;
      div_zero       <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sgn      <= a_sgn ^ b_sgn;
            bmag     <= b_mag;
            dvd      <= ITER'(a_mag) << FRAC_BITS;
            rem      <= '0;
            quot     <= '0;
            cnt      <= CW'(ITER - 1);
            div_zero <= 1'b0;
            overflow <= 1'b0;
            state    <= (b_mag == '0) ? DONE : CALC;
          end
        end
        CALC: begin
          rem  <= ge ? diff[MV-1:0] : trial[MV-1:0];
          quot <= {quot[ITER-2:0], ge};
          dvd  <= dvd << 1;
          if (cnt == '0) begin
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          final_quotient <= q_fmt;
          remainder      <= dz ? '0 : NDV'(rem);
          div_zero       <= dz;
          overflow       <= q_ovf && !dz;
          valid          <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divide_seq.sv
// Directed bench for divide_seq: defaults, sign-magnitude, divide-by-zero, fractional,
// two's-complement, handshake and mid-operation reset.
module tb_divide_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [2:0]  busy_v;
  logic [2:0]  valid_v;
  logic [31:0] q_v [3];
  logic [31:0] r_v [3];
  logic [2:0]  dz_v;
  logic [2:0]  ov_v;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: defaults; 1: 16 fractional bits; 2: two's complement
  divide_seq dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy_v[0]), .valid(valid_v[0]), .final_quotient(q_v[0]), .remainder(r_v[0]),
    .div_zero(dz_v[0]), .overflow(ov_v[0])
  );

  divide_seq #(.FRAC_BITS(16)) dut_frac (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy_v[1]), .valid(valid_v[1]), .final_quotient(q_v[1]), .remainder(r_v[1]),
    .div_zero(dz_v[1]), .overflow(ov_v[1])
  );

  divide_seq #(.SIGN_MAG(0)) dut_tc (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy_v[2]), .valid(valid_v[2]), .final_quotient(q_v[2]), .remainder(r_v[2]),
    .div_zero(dz_v[2]), .overflow(ov_v[2])
  );

  task automatic wait_idle();
    int guard = 0;
    while (busy_v != 3'b000 && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
  endtask

  // Start a divide on all instances; return edges from accept until valid on instance s.
  task automatic do_div(input int s, input logic [31:0] a, input logic [31:0] b,
                        output int cyc);
    wait_idle();
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 32'hFFFF_FFFF;
    divisor  = 32'h0000_1234;
    cyc = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (valid_v[s]) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy_v !== 3'b000) begin errors++;
      $display("FAIL reset_busy got %b want 000", busy_v); end
    checks++; if (valid_v !== 3'b000) begin errors++;
      $display("FAIL reset_valid got %b want 000", valid_v); end
    checks++; if (q_v[0] !== 32'h0 || r_v[0] !== 32'h0) begin errors++;
      $display("FAIL reset_result got q=%h r=%h want 0 0", q_v[0], r_v[0]); end
    checks++; if (dz_v !== 3'b000 || ov_v !== 3'b000) begin errors++;
      $display("FAIL reset_flags got dz=%b ov=%b want 000 000", dz_v, ov_v); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_default();
    int cyc;
    do_div(0, 32'd100, 32'd7, cyc);
    checks++; if (cyc !== 32) begin errors++;
      $display("FAIL default_latency got %0d want 32", cyc); end
    checks++; if (q_v[0] !== 32'd14) begin errors++;
      $display("FAIL default_quot got %h want 0000000e", q_v[0]); end
    checks++; if (r_v[0] !== 32'd2) begin errors++;
      $display("FAIL default_rem got %h want 00000002", r_v[0]); end
    checks++; if (dz_v[0] !== 1'b0 || ov_v[0] !== 1'b0) begin errors++;
      $display("FAIL default_flags got dz=%b ov=%b want 0 0", dz_v[0], ov_v[0]); end
    checks++; if (busy_v[0] !== 1'b0) begin errors++;
      $display("FAIL default_busy_at_valid got %b want 0", busy_v[0]); end
  endtask

  task automatic test_sign_mag();
    int cyc;
    do_div(0, 32'h8000_0064, 32'h0000_0007, cyc);
    checks++; if (q_v[0] !== 32'h8000_000E) begin errors++;
      $display("FAIL sm_neg_pos got %h want 8000000e", q_v[0]); end
    do_div(0, 32'h8000_0064, 32'h8000_0007, cyc);
    checks++; if (q_v[0] !== 32'h0000_000E) begin errors++;
      $display("FAIL sm_neg_neg got %h want 0000000e", q_v[0]); end
    do_div(0, 32'h8000_0000, 32'h0000_0005, cyc);
    checks++; if (q_v[0] !== 32'h0000_0000) begin errors++;
      $display("FAIL sm_neg_zero got %h want 00000000", q_v[0]); end
  endtask

  task automatic test_div_zero();
    int cyc;
    do_div(0, 32'h0000_0123, 32'h8000_0000, cyc);
    checks++; if (cyc !== 1) begin errors++;
      $display("FAIL dz_latency got %0d want 1", cyc); end
    checks++; if (q_v[0] !== 32'h7FFF_FFFF) begin errors++;
      $display("FAIL dz_quot got %h want 7fffffff", q_v[0]); end
    checks++; if (dz_v[0] !== 1'b1 || r_v[0] !== 32'h0 || ov_v[0] !== 1'b0) begin errors++;
      $display("FAIL dz_flags got dz=%b r=%h ov=%b want 1 0 0", dz_v[0], r_v[0], ov_v[0]); end
    // Flag clears at the next accept while the old quotient holds.
    wait_idle();
    @(negedge clk);
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++; if (dz_v[0] !== 1'b0 || q_v[0] !== 32'h7FFF_FFFF) begin errors++;
      $display("FAIL dz_clear got dz=%b q=%h want 0 7fffffff", dz_v[0], q_v[0]); end
    wait_idle();
  endtask

  task automatic test_frac();
    int cyc;
    do_div(1, 32'd1, 32'd3, cyc);
    checks++; if (q_v[1] !== 32'h0000_5555 || ov_v[1] !== 1'b0) begin errors++;
      $display("FAIL frac_third got q=%h ov=%b want 00005555 0", q_v[1], ov_v[1]); end
    do_div(1, 32'h7FFF_FFFF, 32'd1, cyc);
    checks++; if (cyc !== 48) begin errors++;
      $display("FAIL frac_latency got %0d want 48", cyc); end
    checks++; if (q_v[1] !== 32'h7FFF_FFFF || ov_v[1] !== 1'b1) begin errors++;
      $display("FAIL frac_sat got q=%h ov=%b want 7fffffff 1", q_v[1], ov_v[1]); end
  endtask

  task automatic test_twos();
    int cyc;
    do_div(2, 32'hFFFF_FFF9, 32'd2, cyc);
    checks++; if (q_v[2] !== 32'hFFFF_FFFD || r_v[2] !== 32'd1) begin errors++;
      $display("FAIL tc_neg7_2 got q=%h r=%h want fffffffd 1", q_v[2], r_v[2]); end
    do_div(2, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    checks++; if (q_v[2] !== 32'h7FFF_FFFF || ov_v[2] !== 1'b1) begin errors++;
      $display("FAIL tc_min_neg1 got q=%h ov=%b want 7fffffff 1", q_v[2], ov_v[2]); end
  endtask

  task automatic test_handshake();
    int nv = 0;
    wait_idle();
    @(negedge clk);
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Pulses at edges 5 and 10 (busy) and 32 (DONE) must all be ignored.
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      start    = (k == 5 || k == 10 || k == 32);
      dividend = 32'd50;
      divisor  = 32'd5;
      @(posedge clk);
      #1;
      if (valid_v[0]) nv++;
      if (k == 33) begin
        checks++; if (busy_v[0] !== 1'b0) begin errors++;
          $display("FAIL hs_done_start got busy=%b want 0", busy_v[0]); end
      end
    end
    start = 1'b0;
    checks++; if (nv !== 1) begin errors++;
      $display("FAIL hs_valid_count got %0d want 1", nv); end
    checks++; if (q_v[0] !== 32'd14) begin errors++;
      $display("FAIL hs_quot got %h want 0000000e", q_v[0]); end
  endtask

  task automatic test_reset_abort();
    int nv = 0;
    int cyc;
    wait_idle();
    @(negedge clk);
    dividend = 32'd200;
    divisor  = 32'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (busy_v !== 3'b000 || valid_v !== 3'b000) begin errors++;
      $display("FAIL abort_ctrl got busy=%b valid=%b want 000 000", busy_v, valid_v); end
    checks++; if (q_v[0] !== 32'h0 || r_v[0] !== 32'h0 || dz_v[0] !== 1'b0) begin errors++;
      $display("FAIL abort_out got q=%h r=%h dz=%b want 0 0 0", q_v[0], r_v[0], dz_v[0]); end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      #1;
      if (valid_v != 3'b000) nv++;
    end
    checks++; if (nv !== 0) begin errors++;
      $display("FAIL abort_no_valid got %0d want 0", nv); end
    do_div(0, 32'd100, 32'd7, cyc);
    checks++; if (q_v[0] !== 32'd14 || cyc !== 32) begin errors++;
      $display("FAIL abort_redo got q=%h cyc=%0d want 0000000e 32", q_v[0], cyc); end
  endtask

  initial begin
    test_reset();
    test_default();
    test_sign_mag();
    test_div_zero();
    test_frac();
    test_twos();
    test_handshake();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
